// File: rtl/frame_buffer.sv
// Circular sample store feeding pitch detection: every HOP writes it streams the newest FRAME_LEN
// samples oldest-first over valid/ready/last. Define SIGNED_OUT_EN for two's-complement output.
module frame_buffer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 2048,
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned HOP       = 512
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid_in,
    output logic [WIDTH-1:0] frame_data_out,
    output logic             frame_valid_out,
    input  logic             frame_ready_in,
    output logic             frame_last_out,
    output logic             frame_drop_out,
    output logic             overrun_out
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = $clog2(FRAME_LEN + 1);
    localparam int unsigned CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned HW = (HOP > 1) ? $clog2(HOP) : 1;

    localparam logic [FW-1:0] FILL_FULL = FW'(FRAME_LEN);
    localparam logic [FW-1:0] FILL_PRE  = FW'(FRAME_LEN - 1);
    localparam logic [HW-1:0] HOP_MAX   = HW'(HOP - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] LEN_M1    = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StStream} state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr, r_due_start, r_pend_start;
    logic [FW-1:0]    r_fill;
    logic [HW-1:0]    r_hop;
    logic [CW-1:0]    r_cnt;
    logic             r_due, r_pending;
    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_valid, r_last, r_drop, r_overrun;

    logic [AW-1:0]    w_wr_next, w_start, w_ovr_base, w_ovr_remain, w_ovr_off;
    logic             w_hop_wrap, w_due, w_ovr_hit;
    logic [CW-1:0]    w_cnt_inc;
    logic [WIDTH-1:0] w_rd_word;

    assign w_wr_next  = r_wr_ptr + 1'b1;
    assign w_start    = w_wr_next - AW'(FRAME_LEN);
    assign w_hop_wrap = (r_hop == HOP_MAX);
    assign w_due      = sample_valid_in &&
                        ((r_fill == FILL_PRE) || ((r_fill == FILL_FULL) && w_hop_wrap));
    assign w_cnt_inc  = r_cnt + 1'b1;

    // Unfetched words of the active frame occupy [base, base+remain); a write landing there
    // means the reader has been lapped.
    assign w_ovr_base   = (r_state == StFetch) ? r_rd_ptr + 1'b1 : r_rd_ptr;
    assign w_ovr_remain = (r_state == StFetch) ? LEN_M1 : LEN_M1 - AW'(r_cnt);
    assign w_ovr_off    = r_wr_ptr - w_ovr_base;
    assign w_ovr_hit    = sample_valid_in && (r_state != StIdle) && (w_ovr_off < w_ovr_remain);

`ifdef SIGNED_OUT_EN
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    assign w_rd_word = r_mem[r_rd_ptr] ^ MSB_MASK;
`else
    assign w_rd_word = r_mem[r_rd_ptr];
`endif

    always_ff @(posedge clk_in) begin
        if (sample_valid_in) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_hop       <= '0;
            r_due       <= 1'b0;
            r_due_start <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_due <= w_due;
            if (w_due) begin
                r_due_start <= w_start;
            end
            if (sample_valid_in) begin
                r_wr_ptr <= w_wr_next;
                r_hop    <= w_hop_wrap ? '0 : r_hop + 1'b1;
                if (r_fill != FILL_FULL) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
            if (w_ovr_hit) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= StIdle;
            r_rd_ptr     <= '0;
            r_cnt        <= '0;
            r_pending    <= 1'b0;
            r_pend_start <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            // A frame due while busy is parked; a second one supersedes it.
            if ((r_state != StIdle) && r_due) begin
                r_pending    <= 1'b1;
                r_pend_start <= r_due_start;
                if (r_pending) begin
                    r_drop <= 1'b1;
                end
            end
            case (r_state)
                StIdle: begin
                    if (r_due || r_pending) begin
                        r_rd_ptr  <= r_due ? r_due_start : r_pend_start;
                        r_pending <= 1'b0;
                        r_drop    <= r_due && r_pending;
                        r_state   <= StFetch;
                    end
                end
                StFetch: begin
                    r_data   <= w_rd_word;
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_cnt    <= '0;
                    r_last   <= (FRAME_LEN == 1);
                    r_valid  <= 1'b1;
                    r_state  <= StStream;
                end
                StStream: begin
                    if (frame_ready_in) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= StIdle;
                        end else begin
                            r_data   <= w_rd_word;
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                            r_cnt    <= w_cnt_inc;
                            r_last   <= (w_cnt_inc == CNT_LAST);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign frame_data_out  = r_data;
    assign frame_valid_out = r_valid;
    assign frame_last_out  = r_last;
    assign frame_drop_out  = r_drop;
    assign overrun_out     = r_overrun;

endmodule

// File: tb/tb_frame_buffer.sv
// Bench for frame_buffer: expected frames are sliced from a sample-history queue and checked
// in order against every accepted word.
`timescale 1ns/1ps
module tb_frame_buffer;
    localparam int unsigned WIDTH     = 16;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned HOP       = 4;
    // Word index presented when the overrun stall begins; the k-th write after the due write
    // lands on start+FRAME_LEN+k-1, the first unfetched word is start+P_STALL+1.
    localparam int P_STALL = 1;
    localparam int OVR_K   = DEPTH - FRAME_LEN + P_STALL + 2;

    typedef struct {
        logic [15:0] d;
        logic        last;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] sample_in;
    logic        sample_valid_in;
    logic [15:0] frame_data_out;
    logic        frame_valid_out;
    logic        frame_ready_in;
    logic        frame_last_out;
    logic        frame_drop_out;
    logic        overrun_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] hist[$];
    exp_t        exp_q[$];
    int          n_wr;
    bit          sb_en;
    bit          chk_nodrop;
    logic        exp_ovr;
    logic        acc, acc_last;
    logic [15:0] acc_data;

    frame_buffer #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .FRAME_LEN(FRAME_LEN),
        .HOP      (HOP)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .sample_in      (sample_in),
        .sample_valid_in(sample_valid_in),
        .frame_data_out (frame_data_out),
        .frame_valid_out(frame_valid_out),
        .frame_ready_in (frame_ready_in),
        .frame_last_out (frame_last_out),
        .frame_drop_out (frame_drop_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [15:0] conv(input logic [15:0] s);
`ifdef SIGNED_OUT_EN
        return s ^ 16'h8000;
`else
        return s;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input int base);
        for (int i = 0; i < int'(FRAME_LEN); i++) begin
            exp_t e;
            e.d    = hist[base + i];
            e.last = (i == int'(FRAME_LEN) - 1);
            exp_q.push_back(e);
        end
    endtask

    // One clock: drive inputs, score any handshake at the coming edge, update the model.
    task automatic step(input logic wr, input logic [15:0] d, input logic rdy);
        exp_t e;
        sample_valid_in = wr;
        sample_in       = d;
        frame_ready_in  = rdy;
        acc      = frame_valid_out && rdy;
        acc_data = frame_data_out;
        acc_last = frame_last_out;
        if (acc && sb_en) begin
            check("sb_extra", 32'(exp_q.size() == 0), 32'd0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_data", 32'(acc_data), 32'(conv(e.d)));
                check("sb_last", 32'(acc_last), 32'(e.last));
            end
        end
        if (chk_nodrop) check("no_drop", 32'(frame_drop_out), 32'd0);
        check("overrun", 32'(overrun_out), 32'(exp_ovr));
        if (wr) begin
            hist.push_back(d);
            n_wr++;
            if (sb_en && (n_wr == int'(FRAME_LEN) ||
                          (n_wr > int'(FRAME_LEN) && (n_wr % int'(HOP)) == 0))) begin
                push_frame(n_wr - int'(FRAME_LEN));
            end
        end
        @(posedge clk_in);
        #1;
        sample_valid_in = 1'b0;
    endtask

    task automatic drain(input int max_cycles, input bit rnd);
        int c = 0;
        while ((exp_q.size() != 0 || frame_valid_out) && c < max_cycles) begin
            step(1'b0, 16'h0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            c++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int c = 0;
        while (!frame_valid_out && c < 20) begin
            step(1'b0, 16'h0, 1'b0);
            c++;
        end
        check(tag, 32'(frame_valid_out), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200 us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] d0;
        logic        l0;
        int          k, n_drop, words, c;
        bit          done;

        sample_in = '0; sample_valid_in = 1'b0; frame_ready_in = 1'b0; rst_in = 1'b0;
        sb_en = 1'b1; chk_nodrop = 1'b1; exp_ovr = 1'b0; n_wr = 0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_valid", 32'(frame_valid_out), 32'd0);
        check("rst_last", 32'(frame_last_out), 32'd0);
        check("rst_drop", 32'(frame_drop_out), 32'd0);
        check("rst_ovr", 32'(overrun_out), 32'd0);
        check("rst_data", 32'(frame_data_out), 32'd0);
        rst_in = 1'b1;

        // First frame and its latency
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b1);
        check("lat_due", 32'(frame_valid_out), 32'd0);
        step(1'b0, 16'h0, 1'b1);
        check("lat_fetch", 32'(frame_valid_out), 32'd0);
        step(1'b0, 16'h0, 1'b1);
        check("lat_valid", 32'(frame_valid_out), 32'd1);
        check("lat_first", 32'(frame_data_out), 32'(conv(16'd1)));
        drain(40, 1'b0);

        // Overlapping frames, write pointer wraps
        for (int i = 9; i <= 12; i++) step(1'b1, 16'(i), 1'b1);
        drain(40, 1'b0);
        for (int i = 13; i <= 16; i++) step(1'b1, 16'(i), 1'b1);
        drain(40, 1'b0);

        // Long stall: hold, pending, single drop, overrun
        sb_en = 1'b0; chk_nodrop = 1'b0;
        for (int i = 17; i <= 20; i++) step(1'b1, 16'(i), 1'b0);
        wait_valid("s3_valid");
        check("s3_word0", 32'(frame_data_out), 32'(conv(16'd13)));
        step(1'b0, 16'h0, 1'b1);
        d0 = frame_data_out;
        l0 = frame_last_out;
        check("s3_word1", 32'(d0), 32'(conv(16'd14)));
        k = 0; n_drop = 0;
        for (int s = 0; s < 24; s++) begin
            if (s % 2 == 0 && k < 11) begin
                k++;
                step(1'b1, 16'(16'h100 + k), 1'b0);
                exp_ovr = (k >= OVR_K);
            end else begin
                step(1'b0, 16'h0, 1'b0);
            end
            check("s3_hold_valid", 32'(frame_valid_out), 32'd1);
            check("s3_hold_data", 32'(frame_data_out), 32'(d0));
            check("s3_hold_last", 32'(frame_last_out), 32'(l0));
            if (frame_drop_out) n_drop++;
        end
        check("s3_overrun", 32'(overrun_out), 32'd1);
        words = 0; c = 0; done = 1'b0;
        while (!done && c < 40) begin
            step(1'b0, 16'h0, 1'b1);
            c++;
            if (acc) begin
                words++;
                done = acc_last;
            end
            if (frame_drop_out) n_drop++;
        end
        check("s3_tail_words", 32'(words), 32'(FRAME_LEN - 1));
        check("s3_drop_once", 32'(n_drop), 32'd1);
        push_frame(20);
        sb_en = 1'b1; chk_nodrop = 1'b1;
        drain(60, 1'b0);

        // Asynchronous reset in the middle of a frame
        step(1'b1, 16'h0055, 1'b1);
        wait_valid("s4_valid");
        repeat (3) step(1'b0, 16'h0, 1'b1);
        check("s4_word3", 32'(frame_data_out), 32'(conv(hist[27])));
        #2 rst_in = 1'b0;
        #1;
        check("s4_valid0", 32'(frame_valid_out), 32'd0);
        check("s4_last0", 32'(frame_last_out), 32'd0);
        check("s4_drop0", 32'(frame_drop_out), 32'd0);
        check("s4_ovr0", 32'(overrun_out), 32'd0);
        check("s4_data0", 32'(frame_data_out), 32'd0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        exp_q.delete(); hist.delete(); n_wr = 0; exp_ovr = 1'b0;
        for (int i = 1; i <= 7; i++) step(1'b1, 16'(16'h200 + i), 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'h0, 1'b1);
            check("s4_quiet", 32'(frame_valid_out), 32'd0);
        end
        step(1'b1, 16'h0208, 1'b1);
        drain(40, 1'b0);

        // Random backpressure across three frames
        for (int s = 0; s < 96; s++) begin
            if (s % 8 == 0) step(1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
            else            step(1'b0, 16'h0, 1'($urandom_range(0, 1)));
        end
        drain(200, 1'b1);

        // Output coding of the extreme codes
        step(1'b1, 16'h8000, 1'b0);
        step(1'b1, 16'h7FFF, 1'b0);
        step(1'b1, 16'h0001, 1'b0);
        step(1'b1, 16'h0002, 1'b0);
        wait_valid("s6_valid");
        repeat (4) step(1'b0, 16'h0, 1'b1);
        check("s6_8000", 32'(frame_data_out), 32'(conv(16'h8000)));
        step(1'b0, 16'h0, 1'b1);
        check("s6_7fff", 32'(frame_data_out), 32'(conv(16'h7FFF)));
        drain(40, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
